cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Arbitrates functional-unit (FU) results onto the single common data bus (CDB), which broadcasts tag/value to the reservation stations, the ROB and the issue stage's operand snoop. Each FU has a one-entry result holding register. A round-robin arbiter picks one held result per cycle and drives a registered CDB broadcast. The block sits between the FU outputs and the issue stage's `cdb_tag` / `cdb_value` inputs.

Parameters:
NUM_FU, 4, number of FU requesters; must be at least 2.
XLEN, `XLEN, result value width.
TAG_WIDTH, `ROB_SIZE, ROB tag width.
SRC_WIDTH, $clog2(NUM_FU), width of the granted-source index.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active low.
stall_i  in  1  1 = freeze arbitration; no grant and no broadcast.
flush_i  in  1  1 = discard all held results (mispredict recovery).
fu_valid_i  in  NUM_FU  per-FU result valid.
fu_tag_i  in  NUM_FU*TAG_WIDTH  per-FU ROB tag; FU i occupies slice [i*TAG_WIDTH +: TAG_WIDTH].
fu_value_i  in  NUM_FU*XLEN  per-FU result; FU i occupies slice [i*XLEN +: XLEN].
fu_ready_o  out  NUM_FU  per-FU ready; result is accepted when valid and ready are both 1.
cdb_valid_o  out  1  CDB broadcast valid.
cdb_tag_o  out  TAG_WIDTH  broadcast ROB tag.
cdb_value_o  out  XLEN  broadcast value.
cdb_src_o  out  SRC_WIDTH  index of the FU being broadcast.

Behaviour:
- Reset (rst=0, asynchronous):
  - all held flags = 0, RR pointer = 0.
  - cdb_valid_o = 0, cdb_tag_o = 0, cdb_value_o = 0, cdb_src_o = 0.
  - fu_ready_o = 0 while rst=0.
  - Reset takes effect immediately, mid-operation included; held results are lost.
- Holding register per FU: held[i], tag[i], value[i].
- Ready (combinational): fu_ready_o[i] = ~flush_i & (~held[i] | (grant[i] & ~stall_i)).
- Accept: at a clock edge with fu_valid_i[i] & fu_ready_o[i], load tag/value and set held[i]=1.
- Grant (combinational):
  - When stall_i=0 and flush_i=0, grant one-hot to the first held[i] found scanning from the RR pointer upward, wrapping modulo NUM_FU.
  - No held entries → no grant.
- On a grant of FU g at a clock edge:
  - cdb_valid_o=1, cdb_tag_o=tag[g], cdb_value_o=value[g], cdb_src_o=g.
  - held[g] cleared unless a new accept for g occurs in the same edge; in that case the new result replaces it. This gives one result per cycle per FU sustained.
  - RR pointer = (g+1) mod NUM_FU.
- No grant at an edge:
  - cdb_valid_o=0.
  - cdb_tag_o, cdb_value_o and cdb_src_o hold their last values.
  - RR pointer unchanged.
- Latency: fu_valid_i presented in cycle 0 with the FU unheld → accepted at edge 1 → granted in cycle 1 if uncontended → cdb_valid_o=1 in cycle 2.
  - cdb_valid_o is a single-cycle pulse per result.
  - Each tag is broadcast exactly once.
- stall_i=1:
  - No grants; cdb_valid_o=0 after the next edge.
  - Held entries and RR pointer are retained.
  - Unheld FUs may still be accepted.
- flush_i=1:
  - At the next edge all held cleared, cdb_valid_o=0, RR pointer=0.
  - No accepts occur that edge.
  - flush_i has priority over stall_i and over accept.
- Backpressure: a held FU with no grant has fu_ready_o=0. The FU must hold fu_valid_i, tag and value stable until accepted.

Test Plan:
1. FU2 presents tag=4, value=256 in cycle 0, no contention → cdb_valid_o=1 in cycle 2 only, tag 4, value 256, src 2; fu_ready_o[2]=1 throughout.
2. FUs 0-3 present tags 1,2,3,4 in the same cycle, pointer=0 → broadcasts tags 1,2,3,4 in cycles 2,3,4,5 with src 0,1,2,3; fu_ready_o[3]=0 during cycles 1-3.
3. FU0 and FU3 continuously valid with incrementing tags → src sequence alternates 0,3,0,3… with cdb_valid_o=1 every cycle, and neither FU is starved.
4. FUs 1 and 2 held, stall_i=1 for 3 cycles → cdb_valid_o=0 for those cycles; after release, tags broadcast in order src 1 then src 2 with values unchanged.
5. FUs 0 and 1 held, flush_i pulsed for one cycle → cdb_valid_o=0 next cycle; the flushed tags never appear; a new FU1 request afterwards broadcasts with src 1.
6. rst driven low between clock edges while cdb_valid_o=1 and entries are held → cdb_valid_o, cdb_tag_o, cdb_value_o and fu_ready_o go to 0 immediately; after release, no stale broadcast occurs.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Bundles the FU result handshake, the stall/flush controls and
//               the registered common-data-bus broadcast of cdb_arbiter.
//               The master modport is the FU/pipeline side; the slave modport
//               is the arbiter itself.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif

interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int XLEN      = `XLEN,
    parameter int TAG_WIDTH = `ROB_SIZE,
    parameter int SRC_WIDTH = $clog2(NUM_FU)
) ();

    logic                          stall_i;
    logic                          flush_i;
    logic [NUM_FU-1:0]             fu_valid_i;
    logic [NUM_FU*TAG_WIDTH-1:0]   fu_tag_i;
    logic [NUM_FU*XLEN-1:0]        fu_value_i;
    logic [NUM_FU-1:0]             fu_ready_o;
    logic                          cdb_valid_o;
    logic [TAG_WIDTH-1:0]          cdb_tag_o;
    logic [XLEN-1:0]               cdb_value_o;
    logic [SRC_WIDTH-1:0]          cdb_src_o;

    modport master (
        output stall_i,
        output flush_i,
        output fu_valid_i,
        output fu_tag_i,
        output fu_value_i,
        input  fu_ready_o,
        input  cdb_valid_o,
        input  cdb_tag_o,
        input  cdb_value_o,
        input  cdb_src_o
    );

    modport slave (
        input  stall_i,
        input  flush_i,
        input  fu_valid_i,
        input  fu_tag_i,
        input  fu_value_i,
        output fu_ready_o,
        output cdb_valid_o,
        output cdb_tag_o,
        output cdb_value_o,
        output cdb_src_o
    );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter placing functional-unit results onto the
//               single common data bus. Each FU owns a one-entry holding
//               register; one held result per cycle is granted and broadcast
//               through a registered CDB stage.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif

module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int XLEN      = `XLEN,
    parameter int TAG_WIDTH = `ROB_SIZE,
    parameter int SRC_WIDTH = $clog2(NUM_FU)
) (
    input  wire logic       clk,
    input  wire logic       rst,    // asynchronous, active low
    cdb_arbiter_if.slave    bus
);

    localparam logic [SRC_WIDTH:0] c_num_fu = (SRC_WIDTH+1)'(NUM_FU);

    // Holding-register view shared by the arbiter and the CDB stage
    logic [NUM_FU-1:0]      w_held;
    logic [TAG_WIDTH-1:0]   w_tag   [NUM_FU];
    logic [XLEN-1:0]        w_value [NUM_FU];

    // Arbitration and handshake
    logic [NUM_FU-1:0]      w_grant;
    logic [NUM_FU-1:0]      w_ready;
    logic [NUM_FU-1:0]      w_accept;
    logic                   w_gnt_any;
    logic [SRC_WIDTH-1:0]   w_gnt_idx;
    logic [SRC_WIDTH:0]     w_scan;
    logic [SRC_WIDTH:0]     w_ptr_inc;
    logic [SRC_WIDTH-1:0]   w_ptr_next;

    // Broadcast stage
    logic [SRC_WIDTH-1:0]   r_ptr;
    logic                   r_cdb_valid;
    logic [TAG_WIDTH-1:0]   r_cdb_tag;
    logic [XLEN-1:0]        r_cdb_value;
    logic [SRC_WIDTH-1:0]   r_cdb_src;

    // Scan held entries starting at the RR pointer, wrapping modulo NUM_FU;
    // the first held entry found wins. Stall and flush suppress any grant.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        if (!bus.stall_i && !bus.flush_i) begin
            for (int k = 0; k < NUM_FU; k++) begin
                w_scan = {1'b0, r_ptr} + (SRC_WIDTH+1)'(k);
                if (w_scan >= c_num_fu) begin
                    w_scan = w_scan - c_num_fu;
                end
                if (!w_gnt_any && w_held[w_scan[SRC_WIDTH-1:0]]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_scan[SRC_WIDTH-1:0];
                end
            end
        end
    end

    // One-hot grant, handshake ready and accept; a granted FU may refill its
    // slot in the same cycle, giving one result per cycle per FU sustained.
    always_comb begin
        w_grant = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
        w_ready = '0;
        if (rst && !bus.flush_i) begin
            w_ready = ~w_held | w_grant;
        end
        w_accept = bus.fu_valid_i & w_ready;
    end

    // Pointer advances to the entry after the winner, wrapping at NUM_FU
    always_comb begin
        w_ptr_inc  = {1'b0, w_gnt_idx} + (SRC_WIDTH+1)'(1);
        w_ptr_next = (w_ptr_inc == c_num_fu) ? '0 : w_ptr_inc[SRC_WIDTH-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            logic                 r_held;
            logic [TAG_WIDTH-1:0] r_tag;
            logic [XLEN-1:0]      r_value;

            // Per-FU holding register: flush clears, accept loads (overriding
            // the clear of a simultaneous grant), grant alone releases.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_held  <= 1'b0;
                    r_tag   <= '0;
                    r_value <= '0;
                end else if (bus.flush_i) begin
                    r_held  <= 1'b0;
                end else if (w_accept[gi]) begin
                    r_held  <= 1'b1;
                    r_tag   <= bus.fu_tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
                    r_value <= bus.fu_value_i[gi*XLEN +: XLEN];
                end else if (w_grant[gi]) begin
                    r_held  <= 1'b0;
                end
            end

            assign w_held[gi]  = r_held;
            assign w_tag[gi]   = r_tag;
            assign w_value[gi] = r_value;
        end
    endgenerate

    // Registered CDB broadcast and RR pointer; without a grant the payload
    // fields keep their last values and only the valid pulse drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_src   <= '0;
        end else if (bus.flush_i) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
        end else if (w_gnt_any) begin
            r_ptr       <= w_ptr_next;
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_tag[w_gnt_idx];
            r_cdb_value <= w_value[w_gnt_idx];
            r_cdb_src   <= w_gnt_idx;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign bus.fu_ready_o  = w_ready;
    assign bus.cdb_valid_o = r_cdb_valid;
    assign bus.cdb_tag_o   = r_cdb_tag;
    assign bus.cdb_value_o = r_cdb_value;
    assign bus.cdb_src_o   = r_cdb_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter: directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a behavioural model of the holding slots and RR bus.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cdb_arbiter;

    localparam int NUM_FU    = 4;
    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 6;
    localparam int SRC_WIDTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cdb_arbiter_if #(
        .NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .SRC_WIDTH(SRC_WIDTH)
    ) bus ();

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .SRC_WIDTH(SRC_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_held [NUM_FU];
    int          m_tag  [NUM_FU];
    int unsigned m_val  [NUM_FU];
    int          m_ptr;
    bit          m_cv;
    int          m_ct;
    int unsigned m_cval;
    int          m_cs;
    logic [NUM_FU-1:0] last_acc;

    // Random-driver pending requests per FU
    bit          p_v   [NUM_FU];
    int          p_tag [NUM_FU];
    int unsigned p_val [NUM_FU];
    int          next_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_held[i] = 0; m_tag[i] = 0; m_val[i] = 0;
        end
        m_ptr = 0; m_cv = 0; m_ct = 0; m_cval = 0; m_cs = 0;
        last_acc = '0;
    endtask

    // Winner this cycle: first occupied slot going round from the pointer
    function automatic int m_grant();
        if (bus.stall_i || bus.flush_i) return -1;
        for (int k = 0; k < NUM_FU; k++) begin
            if (m_held[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
        end
        return -1;
    endfunction

    function automatic logic [NUM_FU-1:0] m_ready(input int g);
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) begin
            r[i] = !bus.flush_i && (!m_held[i] || g == i);
        end
        return r;
    endfunction

    task automatic set_fu(input int i, input bit v, input int tag, input int unsigned val);
        bus.fu_valid_i[i] = v;
        bus.fu_tag_i[i*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(tag);
        bus.fu_value_i[i*XLEN +: XLEN] = val;
    endtask

    // One clock: inputs already applied; check ready mid-cycle, advance the
    // model, then check the registered broadcast just after the edge.
    task automatic step();
        int g;
        int bt;
        int unsigned bv;
        logic [NUM_FU-1:0] rdy;
        @(negedge clk);
        g   = m_grant();
        rdy = m_ready(g);
        chk("fu_ready", 64'(bus.fu_ready_o), 64'(rdy));
        last_acc = bus.fu_valid_i & rdy;
        if (bus.flush_i) begin
            for (int i = 0; i < NUM_FU; i++) m_held[i] = 0;
            m_cv = 0; m_ptr = 0;
        end else begin
            bt = (g >= 0) ? m_tag[g] : 0;
            bv = (g >= 0) ? m_val[g] : 0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (last_acc[i]) begin
                    m_held[i] = 1;
                    m_tag[i]  = int'(bus.fu_tag_i[i*TAG_WIDTH +: TAG_WIDTH]);
                    m_val[i]  = bus.fu_value_i[i*XLEN +: XLEN];
                end else if (g == i) begin
                    m_held[i] = 0;
                end
            end
            if (g >= 0) begin
                m_cv = 1; m_ct = bt; m_cval = bv; m_cs = g;
                m_ptr = (g + 1) % NUM_FU;
            end else begin
                m_cv = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(bus.cdb_valid_o), 64'(m_cv));
        chk("cdb_tag",   64'(bus.cdb_tag_o),   64'(m_ct));
        chk("cdb_value", 64'(bus.cdb_value_o), 64'(m_cval));
        chk("cdb_src",   64'(bus.cdb_src_o),   64'(m_cs));
    endtask

    task automatic idle(input int n);
        bus.fu_valid_i = '0; bus.stall_i = 0; bus.flush_i = 0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bus.stall_i = 0; bus.flush_i = 0;
        bus.fu_valid_i = '0; bus.fu_tag_i = '0; bus.fu_value_i = '0;
        model_reset();

        // Reset state
        #3;
        chk("rst_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("rst_tag",   64'(bus.cdb_tag_o),   64'd0);
        chk("rst_value", 64'(bus.cdb_value_o), 64'd0);
        chk("rst_src",   64'(bus.cdb_src_o),   64'd0);
        chk("rst_ready", 64'(bus.fu_ready_o),  64'd0);
        @(posedge clk); #1;
        rst = 1;
        idle(2);

        // 1: single uncontended result, two-cycle latency
        set_fu(2, 1, 4, 256);
        step();
        chk("t1_c1_valid", 64'(bus.cdb_valid_o), 64'd0);
        set_fu(2, 0, 4, 256);
        step();
        chk("t1_valid", 64'(bus.cdb_valid_o), 64'd1);
        chk("t1_tag",   64'(bus.cdb_tag_o),   64'd4);
        chk("t1_value", 64'(bus.cdb_value_o), 64'd256);
        chk("t1_src",   64'(bus.cdb_src_o),   64'd2);
        step();
        chk("t1_pulse", 64'(bus.cdb_valid_o), 64'd0);
        idle(1);

        // 2: four simultaneous requests, pointer reset to 0 by a flush first
        bus.flush_i = 1; step(); bus.flush_i = 0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1, i + 1, 32'h100 + i);
        step();
        bus.fu_valid_i = '0;
        for (int c = 0; c < NUM_FU; c++) begin
            step();
            chk("t2_src", 64'(bus.cdb_src_o), 64'(c));
            chk("t2_tag", 64'(bus.cdb_tag_o), 64'(c + 1));
        end
        idle(2);

        // 3: FU0 and FU3 continuously valid with incrementing tags
        next_tag = 10;
        set_fu(0, 1, next_tag, next_tag); next_tag++;
        set_fu(3, 1, next_tag, next_tag); next_tag++;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int i = 0; i < NUM_FU; i++) begin
                if (last_acc[i]) begin
                    set_fu(i, 1, next_tag, next_tag); next_tag++;
                end
            end
        end
        idle(3);

        // 4: FUs 1 and 2 held under a three-cycle stall
        bus.stall_i = 1;
        set_fu(1, 1, 21, 32'hAAAA_0001);
        set_fu(2, 1, 22, 32'hBBBB_0002);
        step();
        bus.fu_valid_i = '0;
        step(); step();
        chk("t4_stall_valid", 64'(bus.cdb_valid_o), 64'd0);
        bus.stall_i = 0;
        step();
        chk("t4_first_src", 64'(bus.cdb_src_o), 64'd1);
        step();
        chk("t4_second_val", 64'(bus.cdb_value_o), 64'hBBBB_0002);
        idle(2);

        // 5: FUs 0 and 1 held then flushed; a fresh FU1 request follows
        bus.stall_i = 1;
        set_fu(0, 1, 31, 31);
        set_fu(1, 1, 32, 32);
        step();
        bus.fu_valid_i = '0;
        bus.stall_i = 0; bus.flush_i = 1;
        step();
        chk("t5_flush_valid", 64'(bus.cdb_valid_o), 64'd0);
        bus.flush_i = 0;
        set_fu(1, 1, 33, 33);
        step();
        bus.fu_valid_i = '0;
        step();
        chk("t5_new_src", 64'(bus.cdb_src_o), 64'd1);
        chk("t5_new_tag", 64'(bus.cdb_tag_o), 64'd33);
        idle(2);

        // 6: asynchronous reset mid-cycle with a broadcast in flight
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1, 40 + i, 40 + i);
        step();
        bus.fu_valid_i = '0;
        step();
        #2;
        rst = 0;
        #1;
        chk("t6_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("t6_tag",   64'(bus.cdb_tag_o),   64'd0);
        chk("t6_value", 64'(bus.cdb_value_o), 64'd0);
        chk("t6_ready", 64'(bus.fu_ready_o),  64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        idle(4);

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < NUM_FU; i++) p_v[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!p_v[i] && ($urandom % 3) != 0) begin
                    p_v[i]   = 1;
                    p_tag[i] = next_tag % (1 << TAG_WIDTH);
                    p_val[i] = $urandom;
                    next_tag++;
                end
                set_fu(i, p_v[i], p_tag[i], p_val[i]);
            end
            bus.stall_i = (($urandom % 8) == 0);
            bus.flush_i = (($urandom % 20) == 0);
            step();
            for (int i = 0; i < NUM_FU; i++) begin
                if (last_acc[i]) p_v[i] = 0;
            end
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
